tc_to_signmag: RTL and testbench



---
 rtl/tc_to_signmag.sv | 107 ++++++++++
 tb/tb_tc_to_signmag.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_to_signmag.sv
// tc_to_signmag: bit-serial two's-complement to sign-magnitude decoder.
// The operand is taken over in_valid/in_ready and walked LSB-first, one bit
// per cycle. The magnitude comes from the copy-until-first-one,
// invert-after rule. The sign and magnitude are then offered over
// out_valid/out_ready. Latency is a fixed WIDTH cycles from accept to
// out_valid.
module tc_to_signmag #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr;        // operand, consumed LSB-first
  logic [WIDTH-1:0] mag;       // magnitude, assembled from the MSB end down
  logic             neg;       // latched operand sign
  logic             seen;      // a 1 has already gone past
  logic [CW-1:0]    cnt;       // index of the bit being processed

  logic             bit_in;
  logic             bit_out;
  logic             last_bit;
  logic             accept;
  logic             handoff;
  logic [WIDTH-1:0] mag_nxt;

  // A negative operand is negated serially. Bits up to and including the
  // first 1 are copied, and later bits are inverted. A non-negative operand
  // is copied unchanged. Zero therefore decodes to +0 and never to -0.
  assign bit_in   = sr[0];
  assign bit_out  = (neg && seen) ? ~bit_in : bit_in;
  assign mag_nxt  = {bit_out, mag[WIDTH-1:1]};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;

  // Next-state logic for the IDLE -> SHIFT -> DONE -> IDLE cycle.
  always_comb begin
    // NOTE: assigning a default before the case gives every path a value,
    // so no latch is inferred when a branch leaves state_nxt untouched.
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    if (handoff)  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // State register. The asynchronous reset abandons any operand in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath. Load the operand on accept, then shift one bit per SHIFT
  // cycle. The finished result is copied into the output registers, which
  // hold it until the next conversion completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      mag      <= '0;
      neg      <= 1'b0;
      seen     <= 1'b0;
      cnt      <= '0;
      out_sign <= 1'b0;
      out_mag  <= '0;
    end else if (accept) begin
      sr   <= in_data;
      neg  <= in_data[WIDTH-1];
      seen <= 1'b0;
      cnt  <= '0;
      mag  <= '0;
    end else if (state == SHIFT) begin
      sr   <= sr >> 1;
      mag  <= mag_nxt;
      seen <= seen | bit_in;
      cnt  <= cnt + CW'(1);
      if (last_bit) begin
        out_sign <= neg;
        out_mag  <= mag_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tc_to_signmag.sv
// Self-checking bench for tc_to_signmag (WIDTH=8). Expected results come from
// a signed-arithmetic reference model and from constant vectors.
module tb_tc_to_signmag;

  localparam int W       = 8;
  localparam int LATENCY = W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;

  int checks   = 0;
  int failures = 0;

  tc_to_signmag #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag)
  );

  always #5 clk = ~clk;

  // Reference model: sign is "value < 0", magnitude is the absolute value.
  function automatic logic ref_sign(input logic [W-1:0] d);
    int v;
    v = int'($signed(d));
    return (v < 0);
  endfunction

  function automatic logic [W-1:0] ref_mag(input logic [W-1:0] d);
    int v;
    v = int'($signed(d));
    if (v < 0) v = -v;
    return v[W-1:0];
  endfunction

  // Present one operand. Returns ok=0 if in_ready never came up.
  // Returns at the falling edge after the accept edge.
  task automatic send(input logic [W-1:0] d, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok       = in_ready;
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count rising edges after the accept edge until out_valid is seen.
  // Returns -1 if the bound expires.
  task automatic wait_valid(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sign !== 1'b0 || out_mag !== '0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b vld=%b sign=%b mag=%h expected rdy=1 vld=0 sign=0 mag=00",
               in_ready, out_valid, out_sign, out_mag);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic;
    bit ok;
    int cyc;
    out_ready = 1'b1;
    send(8'h05, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_accept: in_ready never high");
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy: in_ready=%b expected 0", in_ready);
    end
    wait_valid(cyc);
    checks++;
    if (cyc != LATENCY) begin
      failures++;
      $display("FAIL basic_latency: got %0d expected %0d", cyc, LATENCY);
    end
    checks++;
    if (out_sign !== 1'b0 || out_mag !== 8'h05 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: sign=%b mag=%h rdy=%b expected sign=0 mag=05 rdy=0",
               out_sign, out_mag, in_ready);
    end
    @(posedge clk);  // handoff edge
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_handoff: rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_vectors;
    logic [W-1:0] vin  [4] = '{8'hFB, 8'hFF, 8'h80, 8'h00};
    logic         vsgn [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] vmag [4] = '{8'h05, 8'h01, 8'h80, 8'h00};
    bit ok;
    int cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(vin[i], ok);
      wait_valid(cyc);
      checks++;
      if (!ok || cyc != LATENCY || out_sign !== vsgn[i] || out_mag !== vmag[i]) begin
        failures++;
        $display("FAIL vector_%h: ok=%0d lat=%0d sign=%b mag=%h expected lat=%0d sign=%b mag=%h",
                 vin[i], ok, cyc, out_sign, out_mag, LATENCY, vsgn[i], vmag[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int cyc;
    out_ready = 1'b0;
    send(8'h9C, ok);
    // Hold in_valid high with junk data through SHIFT and DONE; it must be ignored.
    in_valid = 1'b1;
    in_data  = 8'h11;
    wait_valid(cyc);
    checks++;
    if (!ok || cyc != LATENCY || out_sign !== 1'b1 || out_mag !== 8'h64) begin
      failures++;
      $display("FAIL bp_result: ok=%0d lat=%0d sign=%b mag=%h expected lat=%0d sign=1 mag=64",
               ok, cyc, out_sign, out_mag, LATENCY);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sign !== 1'b1 || out_mag !== 8'h64) begin
        failures++;
        $display("FAIL bp_stall_%0d: vld=%b rdy=%b sign=%b mag=%h expected vld=1 rdy=0 sign=1 mag=64",
                 i, out_valid, in_ready, out_sign, out_mag);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sign !== 1'b1 || out_mag !== 8'h64) begin
      failures++;
      $display("FAIL bp_handoff: rdy=%b vld=%b sign=%b mag=%h expected rdy=1 vld=0 sign=1 mag=64",
               in_ready, out_valid, out_sign, out_mag);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int cyc;
    out_ready = 1'b1;
    send(8'hC8, ok);
    repeat (3) @(posedge clk);  // bits 0..2 processed, bit 3 in progress
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sign !== 1'b0 || out_mag !== '0) begin
      failures++;
      $display("FAIL reset_mid: rdy=%b vld=%b sign=%b mag=%h expected rdy=1 vld=0 sign=0 mag=00",
               in_ready, out_valid, out_sign, out_mag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h37, ok);
    wait_valid(cyc);
    checks++;
    if (!ok || cyc != LATENCY || out_sign !== 1'b0 || out_mag !== 8'h37) begin
      failures++;
      $display("FAIL after_reset: ok=%0d lat=%0d sign=%b mag=%h expected lat=%0d sign=0 mag=37",
               ok, cyc, out_sign, out_mag, LATENCY);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_random_sweep;
    bit           ok;
    int           cyc;
    int           stall;
    logic [W-1:0] mask;
    logic [W-1:0] d;
    logic         es;
    logic [W-1:0] em;
    mask = W'($urandom);
    for (int i = 0; i < 256; i++) begin
      d  = W'(i) ^ mask;  // XOR with a fixed byte still visits every value once
      es = ref_sign(d);
      em = ref_mag(d);
      out_ready = 1'b0;
      send(d, ok);
      wait_valid(cyc);
      checks++;
      if (!ok || cyc != LATENCY || out_sign !== es || out_mag !== em) begin
        failures++;
        $display("FAIL sweep_%h: ok=%0d lat=%0d sign=%b mag=%h expected lat=%0d sign=%b mag=%h",
                 d, ok, cyc, out_sign, out_mag, LATENCY, es, em);
      end
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sign !== es || out_mag !== em) begin
          failures++;
          $display("FAIL sweep_stall_%h: vld=%b rdy=%b sign=%b mag=%h expected vld=1 rdy=0 sign=%b mag=%h",
                   d, out_valid, in_ready, out_sign, out_mag, es, em);
        end
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL sweep_handoff_%h: rdy=%b vld=%b expected rdy=1 vld=0", d, in_ready, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_random_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
